// File: rtl/yolo_pkg.sv
// Shared constants and types for the YOLOv3-tiny final-layer OFM result path.
package yolo_pkg;

  localparam int DATA_WIDTH   = 64;
  localparam int OFM_RAM_SIZE = 2378675;

  // Final-layer output region inside the OFM RAM
  localparam int BASE_ADDR    = 1393600;
  localparam int OFM_SIZE     = 5;
  localparam int NUM_FILTER   = 255;
  localparam int TOTAL_WORDS  = NUM_FILTER * OFM_SIZE * OFM_SIZE;

  localparam int ADDR_W = $clog2(OFM_RAM_SIZE);
  localparam int COL_W  = $clog2(OFM_SIZE);
  localparam int CH_W   = $clog2(NUM_FILTER);
  localparam int TAG_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic eor;
    logic eoc;
    logic last;
  } tag_t;

endpackage

// File: rtl/ofm_result_streamer_skid_fifo2.sv
// Two-entry fall-through FIFO: a word pushed into an empty FIFO is visible
// on the output in the same cycle and may be popped without being stored.
module skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             empty;
  logic             store;
  logic             drop;

  assign empty = (count_reg == 2'd0);
  // A push consumed directly by a pop on an empty FIFO never touches storage.
  assign store = push && !(empty && pop);
  assign drop  = pop && !empty;

  assign out_valid = !empty || push;
  assign out_data  = !empty ? mem_reg[rd_ptr_reg] : (push ? push_data : '0);
  assign count     = count_reg;

  always_ff @(posedge clk) begin
    if (store) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (store) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (drop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, store} - {1'b0, drop};
    end
  end

endmodule

// File: rtl/ofm_result_streamer.sv
// Reads the final-layer OFM region after done_CNN and streams it out in
// channel-major, row-major order with row/channel/frame end tags.
module ofm_result_streamer
  import yolo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  ram_rd_en,
  output logic [ADDR_W-1:0]     ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_eor,
  output logic                  m_eoc,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  generate
    if (BASE_ADDR + TOTAL_WORDS > OFM_RAM_SIZE) begin : g_range_check
      $error("final-layer OFM region does not fit in the OFM RAM");
    end
  endgenerate

  state_t                     state_reg;
  logic [ADDR_W-1:0]          rd_ptr_reg;
  logic [COL_W-1:0]           col_reg;
  logic [COL_W-1:0]           row_reg;
  logic [CH_W-1:0]            ch_reg;
  logic                       inflight_reg;
  tag_t                       tag_pipe_reg;
  logic                       done_reg;

  logic [1:0]                 fifo_count;
  logic [2:0]                 occupancy;
  logic                       issue;
  logic                       pop;
  logic                       drain_done;
  tag_t                       issue_tag;
  logic [DATA_WIDTH+TAG_W-1:0] fifo_out;

  // Words held in the FIFO plus the one returning from the RAM never exceed two.
  assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_reg};
  assign issue     = (state_reg == ST_READ) && (occupancy < 3'd2);
  assign pop       = m_valid && m_ready;
  assign drain_done = (occupancy == {2'b0, pop});

  assign issue_tag.eor  = (col_reg == COL_W'(OFM_SIZE - 1));
  assign issue_tag.eoc  = issue_tag.eor && (row_reg == COL_W'(OFM_SIZE - 1));
  assign issue_tag.last = issue_tag.eoc && (ch_reg == CH_W'(NUM_FILTER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      rd_ptr_reg   <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      ch_reg       <= '0;
      inflight_reg <= 1'b0;
      tag_pipe_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      inflight_reg <= issue;
      if (issue) begin
        tag_pipe_reg <= issue_tag;
        rd_ptr_reg   <= rd_ptr_reg + ADDR_W'(1);
        if (issue_tag.eor) begin
          col_reg <= '0;
          if (issue_tag.eoc) begin
            row_reg <= '0;
            ch_reg  <= ch_reg + CH_W'(1);
          end else begin
            row_reg <= row_reg + COL_W'(1);
          end
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end
      case (state_reg)
        ST_IDLE: begin
          // done_reg high means we just finished; a start in that cycle is dropped
          if (start && !done_reg) begin
            state_reg  <= ST_READ;
            rd_ptr_reg <= ADDR_W'(BASE_ADDR);
            col_reg    <= '0;
            row_reg    <= '0;
            ch_reg     <= '0;
          end
        end
        ST_READ: begin
          if (issue && issue_tag.last) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  skid_fifo2 #(
    .WIDTH(DATA_WIDTH + TAG_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg),
    .push_data ({ram_rd_data, tag_pipe_reg}),
    .pop       (pop),
    .out_valid (m_valid),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign m_data    = fifo_out[DATA_WIDTH+TAG_W-1:TAG_W];
  assign m_eor     = fifo_out[2];
  assign m_eoc     = fifo_out[1];
  assign m_last    = fifo_out[0];
  assign ram_rd_en = issue;
  assign ram_addr  = rd_ptr_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;

endmodule

// File: tb/tb_ofm_result_streamer.sv
// Self-checking bench: RAM model with registered read, beat-index reference
// model for data and tags, randomized backpressure and corner sequences.
module tb_ofm_result_streamer;
  import yolo_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  m_ready = 1'b0;
  logic                  ram_rd_en;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data = '0;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_eor;
  logic                  m_eoc;
  logic                  m_last;
  logic                  busy;
  logic                  done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_WIDTH-1:0] pat = '0;
  logic [2:0] cap_tags [TOTAL_WORDS];

  typedef struct {
    int       idx;
    logic [2:0] tags;
  } probe_t;
  probe_t probes [10];

  always #5 clk = ~clk;

  ofm_result_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ram_rd_en   (ram_rd_en),
    .ram_addr    (ram_addr),
    .ram_rd_data (ram_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_eor       (m_eor),
    .m_eoc       (m_eoc),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done)
  );

  // OFM RAM model: mem[BASE_ADDR+i] = i ^ pat, sentinel outside the region
  function automatic logic [DATA_WIDTH-1:0] ram_word(input logic [ADDR_W-1:0] a);
    if (int'(a) >= BASE_ADDR && int'(a) < BASE_ADDR + TOTAL_WORDS)
      return DATA_WIDTH'(int'(a) - BASE_ADDR) ^ pat;
    return {4{16'hDEAD}};
  endfunction

  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= ram_word(ram_addr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctrl"}, 64'({m_valid, ram_rd_en, busy, done, m_eor, m_eoc, m_last}), 64'd0);
    check({name, "_data"}, 64'(m_data), 64'd0);
    check({name, "_addr"}, 64'(ram_addr), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic run_frame(input string label, input int duty, input int stall,
                           input bit extra, input bit start_on_done, input int abort_at);
    int beats = 0;
    int reads = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int first_rd = -1;
    int first_v = -1;
    int reads_at_release = -1;
    int acc0 = -1;
    int acc1 = -1;
    int n_eor = 0;
    int n_eoc = 0;
    int n_last = 0;
    bit stalled = 1'b0;
    bit aborted = 1'b0;
    logic [DATA_WIDTH-1:0] held_d = '0;
    logic [2:0] held_t = '0;
    logic [2:0] exp_t;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == 0) || (extra && cyc > 0 && cyc < 6000 && (cyc % 997) == 500)
              || (start_on_done && cyc == TOTAL_WORDS + 2);
      m_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < duty);
      #1;
      if (stalled) begin
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_data", 64'(m_data), 64'(held_d));
        check("stall_tags", 64'({m_eor, m_eoc, m_last}), 64'(held_t));
      end
      if (stall > 0 && cyc == stall) reads_at_release = reads;
      if (ram_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        check("rd_addr", 64'(ram_addr), 64'(BASE_ADDR + reads));
        reads++;
        check("fifo_bound", 64'(reads - beats <= 2), 64'd1);
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        exp_t = {(beats % 5) == 4, (beats % 25) == 24, beats == TOTAL_WORDS - 1};
        check("beat_in_range", 64'(beats < TOTAL_WORDS), 64'd1);
        check("beat_data", 64'(m_data), 64'(DATA_WIDTH'(beats) ^ pat));
        check("beat_tags", 64'({m_eor, m_eoc, m_last}), 64'(exp_t));
        if (beats < TOTAL_WORDS) cap_tags[beats] = {m_eor, m_eoc, m_last};
        n_eor += int'(m_eor);
        n_eoc += int'(m_eoc);
        n_last += int'(m_last);
        if (beats == 0) acc0 = cyc;
        if (beats == 1) acc1 = cyc;
        beats++;
      end
      stalled = m_valid && !m_ready;
      held_d = m_data;
      held_t = {m_eor, m_eoc, m_last};
      if (done_cyc >= 0 && cyc > done_cyc) begin
        check("tail_idle", 64'({busy, ram_rd_en}), 64'd0);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (abort_at >= 0 && beats == abort_at) begin
        aborted = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        start = 1'b0;
        m_ready = 1'b0;
        repeat (2) begin
          @(posedge clk);
          #1 check("reset_no_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        break;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    start = 1'b0;
    m_ready = 1'b0;
    if (aborted) begin
      check("abort_no_done", 64'(done_cnt), 64'd0);
    end else begin
      check("frame_finished", 64'(done_cyc >= 0), 64'd1);
      check("beat_count", 64'(beats), 64'(TOTAL_WORDS));
      check("read_count", 64'(reads), 64'(TOTAL_WORDS));
      check("done_pulses", 64'(done_cnt), 64'd1);
      check("eor_total", 64'(n_eor), 64'd1275);
      check("eoc_total", 64'(n_eoc), 64'd255);
      check("last_total", 64'(n_last), 64'd1);
      if (stall == 0) begin
        check("first_rd_cycle", 64'(first_rd), 64'd1);
        check("first_valid_cycle", 64'(first_v), 64'd2);
      end
      if (duty == 100 && stall == 0) begin
        check("done_cycle", 64'(done_cyc), 64'(TOTAL_WORDS + 2));
      end
      if (stall > 0) begin
        check("reads_while_stalled", 64'(reads_at_release), 64'd2);
        check("beat0_cycle", 64'(acc0), 64'(stall));
        check("beat1_cycle", 64'(acc1), 64'(stall + 1));
      end
    end
    $display("frame %s: beats=%0d reads=%0d done_cycle=%0d aborted=%0d",
             label, beats, reads, done_cyc, aborted);
  endtask

  initial begin
    probes[0] = '{0,    3'b000};
    probes[1] = '{3,    3'b000};
    probes[2] = '{4,    3'b100};
    probes[3] = '{5,    3'b000};
    probes[4] = '{24,   3'b110};
    probes[5] = '{25,   3'b000};
    probes[6] = '{49,   3'b110};
    probes[7] = '{6369, 3'b100};
    probes[8] = '{6373, 3'b000};
    probes[9] = '{6374, 3'b111};

    rst_n = 1'b0;
    idle(3);
    #1 check_outputs_zero("reset_state");
    rst_n = 1'b1;
    idle(3);

    pat = '0;
    run_frame("full", 100, 0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("probe_tags_%0d", probes[i].idx),
            64'(cap_tags[probes[i].idx]), 64'(probes[i].tags));
    end

    idle(3);
    pat = {$urandom, $urandom};
    run_frame("backpressure", 30, 0, 1'b0, 1'b0, -1);

    idle(3);
    pat = {$urandom, $urandom};
    run_frame("stall", 100, 100, 1'b0, 1'b0, -1);

    idle(3);
    run_frame("extra_start", 100, 0, 1'b1, 1'b1, -1);
    idle(3);
    #1 check("idle_after_start_on_done", 64'({busy, ram_rd_en}), 64'd0);

    idle(3);
    run_frame("reset_mid", 100, 0, 1'b0, 1'b0, 1000);

    idle(3);
    pat = '0;
    run_frame("restart", 100, 0, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
